// File: rtl/gsm_air_pkg.sv
// Shared GSM air-interface constants and feeder FSM encoding.
// gmsk_modulate imports this package as well.
package gsm_air_pkg;

    localparam int BURST_BITS      = 148;
    localparam int BYTES_PER_BURST = 19;

    // Idle and guard periods transmit a constant data value.
    localparam logic FILL_BIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA       = 2'd1,
        GUARD      = 2'd2,
        GUARD_TAIL = 2'd3
    } feed_state_t;

    function automatic logic diff_encode(input logic d, input logic d_prev);
        return d ^ d_prev;
    endfunction

endpackage

// File: rtl/gsm_sample_divider.sv
// Free-running divider: one-clock sample_strobe every SAMPLE_DIV clocks.
// The first pulse appears SAMPLE_DIV clocks after reset is released.
module gsm_sample_divider #(
    parameter int SAMPLE_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic sample_strobe
);

    localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] ZERO       = CW'(0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          strobe_q;
    logic          strobe_d;

    // Next count and strobe: the pulse is registered on the wrap clock.
    always_comb begin
        count_d  = count_q;
        strobe_d = 1'b0;
        if (count_q == LAST_COUNT) begin
            count_d  = ZERO;
            strobe_d = 1'b1;
        end else begin
            count_d  = count_q + ONE;
            strobe_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= ZERO;
            strobe_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            strobe_q <= strobe_d;
        end
    end

    assign sample_strobe = strobe_q;

endmodule

// File: rtl/gsm_burst_feeder.sv
// Burst feeder for gmsk_modulate: byte intake, MSB-first serialisation,
// GSM differential encoding, guard insertion and sample_strobe pacing.
module gsm_burst_feeder
    import gsm_air_pkg::*;
#(
    parameter int SAMPLE_DIV = 4,
    parameter int GUARD_BITS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       next_symbol_strobe,
    output logic       current_symbol,
    output logic       sample_strobe,
    output logic       burst_active,
    output logic       burst_done,
    output logic       underrun
);

    localparam logic [7:0] PAYLOAD_BITS = 8'(BURST_BITS);
    localparam logic [3:0] TAIL_ENTRY   = 4'(GUARD_BITS - 2);

    feed_state_t state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  bits_left_q, bits_left_d;
    logic [7:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  guard_cnt_q, guard_cnt_d;
    logic        d_prev_q, d_prev_d;
    logic        sym_q, sym_d;
    logic        nss_q, nss_d;
    logic        byte_ready_q, byte_ready_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        urun_q, urun_d;

    logic        advance;
    logic        load;
    logic        data_bit;
    logic        emit_pay;
    logic        enter_guard;
    logic [7:0]  pay_base;

    gsm_sample_divider #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_divider (
        .clock         (clock),
        .reset         (reset),
        .sample_strobe (sample_strobe)
    );

    assign advance = next_symbol_strobe & ~nss_q;
    assign load    = byte_valid & byte_ready_q;
    assign nss_d   = next_symbol_strobe;

    // Next-state logic. Order matters: a byte accepted this clock reaches
    // the shift register before an advance on the same clock consumes it.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        bit_cnt_d   = bit_cnt_q;
        guard_cnt_d = guard_cnt_q;
        d_prev_d    = d_prev_q;
        sym_d       = sym_q;
        active_d    = active_q;
        urun_d      = urun_q;
        done_d      = 1'b0;
        data_bit    = FILL_BIT;
        emit_pay    = 1'b0;
        enter_guard = 1'b0;
        pay_base    = bit_cnt_q;

        if (load) begin
            hold_d     = byte_data;
            hold_vld_d = 1'b1;
        end else begin
            hold_d     = hold_q;
            hold_vld_d = hold_vld_q;
        end

        if ((bits_left_q == 4'd0) && hold_vld_d) begin
            shift_d     = hold_d;
            bits_left_d = 4'd8;
            hold_vld_d  = 1'b0;
        end else begin
            shift_d     = shift_q;
            bits_left_d = bits_left_q;
        end

        if (advance) begin
            case (state_q)
                IDLE: begin
                    if (bits_left_d != 4'd0) begin
                        emit_pay = 1'b1;
                        pay_base = 8'd0;
                        active_d = 1'b1;
                        state_d  = DATA;
                    end else begin
                        data_bit = FILL_BIT;
                    end
                end
                DATA: begin
                    emit_pay = 1'b1;
                end
                GUARD: begin
                    guard_cnt_d = guard_cnt_q + 4'd1;
                    if (guard_cnt_q == TAIL_ENTRY) begin
                        state_d = GUARD_TAIL;
                    end else begin
                        state_d = GUARD;
                    end
                end
                GUARD_TAIL: begin
                    guard_cnt_d = guard_cnt_q + 4'd1;
                    done_d      = 1'b1;
                    // A byte already buffered starts the next burst seamlessly.
                    if (bits_left_d != 4'd0) begin
                        state_d   = DATA;
                        bit_cnt_d = 8'd0;
                    end else begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (emit_pay) begin
                if (bits_left_d == 4'd0) begin
                    urun_d      = 1'b1;
                    enter_guard = 1'b1;
                end else begin
                    data_bit    = shift_d[7];
                    shift_d     = {shift_d[6:0], 1'b0};
                    bits_left_d = bits_left_d - 4'd1;
                    bit_cnt_d   = pay_base + 8'd1;
                    urun_d      = (pay_base == 8'd0) ? 1'b0 : urun_q;
                    enter_guard = ((pay_base + 8'd1) == PAYLOAD_BITS);
                end
            end else begin
                bit_cnt_d = bit_cnt_d;
            end

            // Flushing here drops the unused low nibble of the last payload byte.
            if (enter_guard) begin
                shift_d     = 8'd0;
                bits_left_d = 4'd0;
                guard_cnt_d = 4'd0;
                state_d     = (GUARD_BITS == 1) ? GUARD_TAIL : GUARD;
            end else begin
                guard_cnt_d = guard_cnt_d;
            end

            sym_d    = diff_encode(data_bit, d_prev_q);
            d_prev_d = data_bit;
        end else begin
            sym_d    = sym_q;
            d_prev_d = d_prev_q;
        end

        byte_ready_d = ~hold_vld_d & (state_d != GUARD_TAIL);
    end

    // Feeder state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= 8'd0;
            hold_vld_q   <= 1'b0;
            shift_q      <= 8'd0;
            bits_left_q  <= 4'd0;
            bit_cnt_q    <= 8'd0;
            guard_cnt_q  <= 4'd0;
            d_prev_q     <= 1'b1;
            sym_q        <= 1'b0;
            nss_q        <= 1'b0;
            byte_ready_q <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            urun_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            shift_q      <= shift_d;
            bits_left_q  <= bits_left_d;
            bit_cnt_q    <= bit_cnt_d;
            guard_cnt_q  <= guard_cnt_d;
            d_prev_q     <= d_prev_d;
            sym_q        <= sym_d;
            nss_q        <= nss_d;
            byte_ready_q <= byte_ready_d;
            active_q     <= active_d;
            done_q       <= done_d;
            urun_q       <= urun_d;
        end
    end

    assign byte_ready     = byte_ready_q;
    assign current_symbol = sym_q;
    assign burst_active   = active_q;
    assign burst_done     = done_q;
    assign underrun       = urun_q;

endmodule

// File: tb/tb_gsm_burst_feeder.sv
// Scoreboard bench for gsm_burst_feeder: a bit-level model of the burst
// framing and differential encoder predicts every advance.
module tb_gsm_burst_feeder;

    localparam int SAMPLE_DIV = 4;
    localparam int GUARD_BITS = 8;
    localparam int NPAY       = 148;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       next_symbol_strobe = 1'b0;
    logic       byte_ready;
    logic       current_symbol;
    logic       sample_strobe;
    logic       burst_active;
    logic       burst_done;
    logic       underrun;

    typedef struct packed {
        logic sym;
        logic active;
        logic urun;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] byte_q[$];
    logic [7:0] pl [0:37];

    int   check_cnt = 0;
    int   error_cnt = 0;
    int   hs_cnt    = 0;
    int   done_cnt  = 0;
    int   exp_done  = 0;
    logic m_dprev   = 1'b1;
    logic m_urun    = 1'b0;
    logic m_active  = 1'b0;

    always #5 clock = ~clock;

    gsm_burst_feeder #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .GUARD_BITS (GUARD_BITS)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .byte_data          (byte_data),
        .byte_valid         (byte_valid),
        .byte_ready         (byte_ready),
        .next_symbol_strobe (next_symbol_strobe),
        .current_symbol     (current_symbol),
        .sample_strobe      (sample_strobe),
        .burst_active       (burst_active),
        .burst_done         (burst_done),
        .underrun           (underrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (burst_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
        end
    end

    // Byte source: presents byte_q[0] with byte_valid until it is taken.
    initial begin
        bit took;
        forever begin
            @(negedge clock);
            took = byte_valid && (byte_ready === 1'b1);
            if (took) hs_cnt++;
            @(posedge clock);
            #1;
            if (took && byte_q.size() > 0) void'(byte_q.pop_front());
            if (byte_q.size() > 0) begin
                byte_valid = 1'b1;
                byte_data  = byte_q[0];
            end else begin
                byte_valid = 1'b0;
                byte_data  = 8'h00;
            end
        end
    end

    task automatic push_bit(input logic d, input logic act, input logic ur);
        exp_t e;
        e.sym    = d ^ m_dprev;
        e.active = act;
        e.urun   = ur;
        m_dprev  = d;
        exp_q.push_back(e);
    endtask

    task automatic push_idle();
        push_bit(1'b1, m_active, m_urun);
    endtask

    task automatic queue_burst(input int base, input int nbytes, input bit more);
        int npay;
        logic [7:0] x;
        npay = (nbytes * 8 < NPAY) ? nbytes * 8 : NPAY;
        for (int b = 0; b < nbytes; b++) byte_q.push_back(pl[base + b]);
        m_urun = 1'b0;
        for (int i = 0; i < npay; i++) begin
            x = pl[base + i / 8];
            push_bit(x[7 - (i % 8)], 1'b1, 1'b0);
        end
        if (npay < NPAY) begin
            m_urun = 1'b1;
            push_bit(1'b1, 1'b1, 1'b1);
        end
        for (int g = 0; g < GUARD_BITS; g++) begin
            push_bit(1'b1, (g == GUARD_BITS - 1) ? more : 1'b1, m_urun);
        end
        m_active = more;
        exp_done++;
    endtask

    task automatic advance(input int hold);
        exp_t e;
        @(posedge clock);
        #2 next_symbol_strobe = 1'b1;
        repeat (hold) @(posedge clock);
        #2 next_symbol_strobe = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("current_symbol", {31'd0, current_symbol}, {31'd0, e.sym});
            check_eq("burst_active",   {31'd0, burst_active},   {31'd0, e.active});
            check_eq("underrun",       {31'd0, underrun},       {31'd0, e.urun});
        end
    endtask

    task automatic run_advances(input int n);
        for (int k = 0; k < n; k++) advance(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state and divider cadence.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_current_symbol", {31'd0, current_symbol}, 32'd0);
        check_eq("rst_sample_strobe",  {31'd0, sample_strobe},  32'd0);
        check_eq("rst_byte_ready",     {31'd0, byte_ready},     32'd0);
        check_eq("rst_burst_active",   {31'd0, burst_active},   32'd0);
        check_eq("rst_burst_done",     {31'd0, burst_done},     32'd0);
        check_eq("rst_underrun",       {31'd0, underrun},       32'd0);
        @(posedge clock);
        #2 reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock);
            #1;
            check_eq("sample_strobe", {31'd0, sample_strobe}, {31'd0, (c % SAMPLE_DIV) == 0});
        end
        for (int k = 0; k < 4; k++) push_idle();
        run_advances(4);

        // All-zero burst.
        for (int b = 0; b < 38; b++) pl[b] = 8'h00;
        hs_cnt = 0;
        queue_burst(0, 19, 1'b0);
        repeat (6) @(posedge clock);
        run_advances(NPAY + GUARD_BITS);
        check_eq("zero_handshakes", hs_cnt, 32'd19);
        check_eq("zero_burst_done", done_cnt, exp_done);

        // Alternating pattern burst.
        for (int b = 0; b < 38; b++) pl[b] = 8'hAA;
        hs_cnt = 0;
        queue_burst(0, 19, 1'b0);
        repeat (6) @(posedge clock);
        run_advances(NPAY + GUARD_BITS);
        check_eq("aa_handshakes", hs_cnt, 32'd19);
        check_eq("aa_burst_done", done_cnt, exp_done);

        // Starved burst: five bytes only.
        for (int b = 0; b < 38; b++) pl[b] = 8'($urandom_range(0, 255));
        queue_burst(0, 5, 1'b0);
        repeat (6) @(posedge clock);
        run_advances(40 + 1 + GUARD_BITS);
        check_eq("starve_burst_done", done_cnt, exp_done);
        push_idle();
        push_idle();
        run_advances(2);

        // Two bursts queued back to back.
        for (int b = 0; b < 38; b++) pl[b] = 8'($urandom_range(0, 255));
        hs_cnt = 0;
        queue_burst(0, 19, 1'b1);
        queue_burst(19, 19, 1'b0);
        repeat (6) @(posedge clock);
        run_advances(2 * (NPAY + GUARD_BITS));
        check_eq("b2b_handshakes", hs_cnt, 32'd38);
        check_eq("b2b_burst_done", done_cnt, exp_done);

        // Held strobe, then reset in the middle of a burst.
        for (int b = 0; b < 38; b++) pl[b] = 8'($urandom_range(0, 255));
        queue_burst(0, 19, 1'b0);
        repeat (6) @(posedge clock);
        advance(10);
        run_advances(59);
        exp_q.delete();
        exp_done--;
        @(posedge clock);
        #2 reset = 1'b1;
        byte_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("midrst_burst_active", {31'd0, burst_active}, 32'd0);
        check_eq("midrst_byte_ready",   {31'd0, byte_ready},   32'd0);
        check_eq("midrst_symbol",       {31'd0, current_symbol}, 32'd0);
        @(posedge clock);
        #2 reset = 1'b0;
        m_dprev  = 1'b1;
        m_active = 1'b0;
        m_urun   = 1'b0;
        @(posedge clock);
        #1;
        check_eq("release_byte_ready", {31'd0, byte_ready}, 32'd1);
        repeat (4) @(posedge clock);
        check_eq("midrst_no_done", done_cnt, exp_done);
        push_idle();
        push_idle();
        run_advances(2);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
